ntt_stream_core: RTL and testbench
==================================

// Module: ntt_stream_core
// PURPOSE
//  Parametrised, fully pipelined N-point cyclic NTT/iNTT over Z_Q. Per-vector mode selects direction.
//  Accepts one N-coefficient vector per cycle. Successor to the fixed 8-point iNTT.
//  Sits between the NTT controller and the pointwise-multiply stage of the Kyber datapath.
// PARAMETERS
//  N         8     points per vector; power of 2, 4..256; LOGN = $clog2(N)
//  W         12    coefficient width; Q < 2**W
//  Q         3329  prime modulus
//  OMEGA     2580  primitive N-th root of unity mod Q (forward twiddle base)
//  OMEGA_INV 40    OMEGA^-1 mod Q (inverse twiddle base)
//  N_INV     2913  N^-1 mod Q (inverse output scaling)
// PORTS
//  clk        in   1       clock; all flops on rising edge
//  r          in   1       reset, asynchronous assert, active-low (0 = reset)
//  valid_in   in   1       input vector valid
//  mode_in    in   1       0 = forward NTT, 1 = inverse NTT (sampled with valid_in)
//  coeffs     in   W x N   input vector, natural order, each value in [0,Q-1]
//  valid_out  out  1       output vector valid
//  mode_out   out  1       mode travelling with the output vector
//  coeffs_out out  W x N   result vector, natural order, each value in [0,Q-1]
//  in_ready   out  1       only with NTT_BACKPRESSURE_EN; input accepted when high
//  out_ready  in   1       only with NTT_BACKPRESSURE_EN; downstream can take output
// BEHAVIOUR
//  - Reset (r=0): all valid flags, valid_out, mode_out and coeffs_out go to 0 immediately.
//    In-flight vectors are discarded. A vector presented on the first edge after r=1 is processed normally.
//  - Transfer: an input transfers on a rising edge with valid_in=1 (and in_ready=1 when that feature is built).
//    No bubbles are required between vectors.
//  - Latency: fixed at 2*LOGN+1 cycles from the transfer edge to valid_out=1, for both modes (N=8: 7).
//    Throughput is 1 vector/cycle. Output order equals input order.
//  - Pipeline: LOGN butterfly stages, 2 registers each.
//    * Register 1: twiddle multiply b*w mod Q.
//    * Register 2: a+t mod Q and a-t mod Q.
//    * Final register: multiply by N_INV when mode=1; pass-through when mode=0.
//  - Twiddles: stage twiddles are OMEGA^k (mode 0) or OMEGA_INV^k (mode 1), k in [0,N/2-1].
//    They are built at elaboration from parameters; no runtime ROM loading.
//    Bit-reversal is pure wiring, so both ports stay in natural order.
//  - Arithmetic:
//    * Add/sub use W+1 bits with one conditional +/-Q correction.
//    * Multiply is 2W bits reduced by Barrett (k = 2W); the result is always < Q.
//    * Q-1 + Q-1 -> Q-2; 0 - (Q-1) -> 1.
//  - Mode: a per-vector flag carried alongside the data. Back-to-back vectors of mixed modes are legal.
//  - valid_in=0: the stage valid goes 0 and the data registers may hold stale values.
//    coeffs_out is don't-care while valid_out=0, except after reset, where it is 0.
//  - Inputs >= Q are outside the contract; the output is undefined but must not hang the pipeline.
// CONFIGURATION
//  NTT_BACKPRESSURE_EN defined:
//    - in_ready = !(valid_out && !out_ready).
//    - When in_ready=0 the whole pipeline stalls: every register holds, and valid_out/coeffs_out stay stable.
//    - Latency counts only non-stalled cycles.
//  NTT_BACKPRESSURE_EN undefined:
//    - in_ready and out_ready ports are absent; the block never stalls.
//    - The output is valid for exactly one cycle.
// TESTING
//  1 Reset: r=0 mid-stream with 3 vectors in flight -> valid_out=0, coeffs_out all 0 at once;
//    after r=1 no stale vector emerges.
//  2 Forward: mode 0, [1,0,0,0,0,0,0,0] -> [1,1,1,1,1,1,1,1] exactly 7 cycles later;
//    [1,1,1,1,1,1,1,1] -> [8,0,0,0,0,0,0,0].
//  3 Inverse: mode 1, [8,0,0,0,0,0,0,0] -> [1,1,1,1,1,1,1,1]; [1,1,...,1] -> [1,0,...,0];
//    all 3328 -> [3328,0,...,0].
//  4 Round trip, back to back: forward [1..8] then [10,20,...,80] on consecutive cycles.
//    Feed the results into inverse -> returns [1..8] and [10..80]; mode_out matches each vector.
//  5 Mixed modes: alternate mode 0/1 every cycle for 20 random vectors.
//    Every output equals the reference model, and valid_out is high for 20 consecutive cycles.
//  6 NTT_BACKPRESSURE_EN: hold out_ready=0 for 5 cycles while streaming.
//    -> in_ready=0 and coeffs_out stable; no vector is lost or duplicated after release.

Source files
------------

// File: rtl/ntt_stream_core.sv
// -----------------------------------------------------------------------------
// ntt_stream_core
//   Fully pipelined N-point cyclic NTT / inverse NTT over Z_Q. It accepts one
//   N-coefficient vector per cycle, and each vector carries its own direction
//   flag. The core is a radix-2 decimation-in-time network. The input
//   bit-reversal is plain wiring, so both ports use natural order. Each of the
//   LOGN stages has two registers: a twiddle multiply, then an add/sub.
//   A final register applies the N^-1 scaling to inverse vectors. The
//   latency is 2*LOGN+1 clocks.
//
// Ports
//   clk        in   clock, rising edge
//   r          in   asynchronous active-low reset
//   valid_in   in   input vector valid
//   mode_in    in   0 = forward NTT, 1 = inverse NTT
//   coeffs     in   N x W input vector, natural order, element i = coeffs[i]
//   valid_out  out  output vector valid
//   mode_out   out  mode of the output vector
//   coeffs_out out  N x W result vector, natural order
//   in_ready   out  (NTT_BACKPRESSURE_EN only) input accepted when high
//   out_ready  in   (NTT_BACKPRESSURE_EN only) downstream can take output
//
// Build option
//   NTT_BACKPRESSURE_EN : if defined, the whole pipeline freezes while the
//                         output is valid and not taken. If undefined, the
//                         core never stalls and each output lasts one cycle.
// -----------------------------------------------------------------------------
module ntt_stream_core #(
    parameter int unsigned N         = 8,
    parameter int unsigned W         = 12,
    parameter int unsigned Q         = 3329,
    parameter int unsigned OMEGA     = 2580,
    parameter int unsigned OMEGA_INV = 40,
    parameter int unsigned N_INV     = 2913
) (
    input  logic                clk,
    input  logic                r,
    input  logic                valid_in,
    input  logic                mode_in,
    input  logic [N-1:0][W-1:0] coeffs,
    output logic                valid_out,
    output logic                mode_out,
    output logic [N-1:0][W-1:0] coeffs_out
`ifdef NTT_BACKPRESSURE_EN
    ,
    output logic                in_ready,
    input  logic                out_ready
`endif
);

    localparam int unsigned LOGN   = $clog2(N);
    localparam int unsigned HALF_N = N / 2;

    typedef logic [N-1:0][W-1:0]      vec_t;
    typedef logic [HALF_N-1:0][W-1:0] tw_t;

    // Barrett constant for k = 2W: floor(2^(2W) / Q).
    localparam logic [2*W:0] BARRETT_MU = (2*W+1)'((64'd1 << (2*W)) / 64'(Q));

    // ---------------------------------------------------------------------
    // Elaboration-time helpers
    // ---------------------------------------------------------------------
    function automatic tw_t make_twiddles(input int unsigned base);
        tw_t             tw;
        longint unsigned acc;
        tw  = '0;
        acc = 64'd1;
        for (int k = 0; k < int'(HALF_N); k++) begin
            tw[k] = W'(acc);
            acc   = (acc * 64'(base)) % 64'(Q);
        end
        return tw;
    endfunction

    function automatic int bit_rev(input int idx);
        int res;
        res = 0;
        for (int b = 0; b < int'(LOGN); b++) begin
            res = res | (((idx >> b) & 1) << (int'(LOGN) - 1 - b));
        end
        return res;
    endfunction

    // Index of the upper leg of butterfly number b in a stage with span half.
    function automatic int bf_top(input int b, input int half);
        return (b / half) * 2 * half + (b % half);
    endfunction

    localparam tw_t TW_FWD = make_twiddles(OMEGA);
    localparam tw_t TW_INV = make_twiddles(OMEGA_INV);

    // ---------------------------------------------------------------------
    // Modular arithmetic
    // ---------------------------------------------------------------------
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (W+1)'(Q)) s = s - (W+1)'(Q);
        return W'(s);
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) d = d + (W+1)'(Q);
        return W'(d);
    endfunction

    // For any product below 2^(2W), the quotient estimate is short by at
    // most one. A single correction therefore gives a result below Q.
    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] x;
        logic [4*W:0]   prod;
        logic [2*W-1:0] q_est;
        logic [2*W-1:0] rem;
        x     = (2*W)'(a) * (2*W)'(b);
        prod  = (4*W+1)'(x) * (4*W+1)'(BARRETT_MU);
        q_est = (2*W)'(prod >> (2*W));
        rem   = x - q_est * (2*W)'(Q);
        if (rem >= (2*W)'(Q)) rem = rem - (2*W)'(Q);
        return W'(rem);
    endfunction

    function automatic logic [W-1:0] twiddle(input logic inv, input int k);
        return inv ? TW_INV[k] : TW_FWD[k];
    endfunction

    // ---------------------------------------------------------------------
    // Global advance: every register moves together or holds together.
    // ---------------------------------------------------------------------
    logic w_adv;
`ifdef NTT_BACKPRESSURE_EN
    assign in_ready = !(valid_out && !out_ready);
    assign w_adv    = in_ready;
`else
    assign w_adv    = 1'b1;
`endif

    // ---------------------------------------------------------------------
    // Inter-stage links: index s is the input of stage s, index LOGN feeds
    // the final scaling register.
    // ---------------------------------------------------------------------
    vec_t          w_data [LOGN+1];
    logic [LOGN:0] w_vld;
    logic [LOGN:0] w_mode;
    vec_t          w_bitrev;

    // NOTE: each combinational block assigns a full default first. This
    // keeps every path driven and avoids inferred latches.
    always_comb begin
        w_bitrev = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_bitrev[i] = coeffs[bit_rev(i)];
        end
    end

    assign w_data[0] = w_bitrev;
    assign w_vld[0]  = valid_in;
    assign w_mode[0] = mode_in;

    for (genvar s = 0; s < int'(LOGN); s++) begin : g_stage
        localparam int HALF = 1 << s;
        localparam int STEP = int'(N) >> (s + 1);

        vec_t w_mul_d;
        vec_t w_bf_d;
        vec_t r_mul;
        vec_t r_bf;
        logic r_vld_mul;
        logic r_mode_mul;
        logic r_vld_bf;
        logic r_mode_bf;

        // Register 1: lower leg times OMEGA^(j*N/2^(s+1)). The upper leg
        // passes through unchanged.
        always_comb begin
            w_mul_d = w_data[s];
            for (int b = 0; b < int'(HALF_N); b++) begin
                w_mul_d[bf_top(b, HALF) + HALF] =
                    mod_mul(w_data[s][bf_top(b, HALF) + HALF], twiddle(w_mode[s], (b % HALF) * STEP));
            end
        end

        // Register 2: upper = a + t, lower = a - t.
        always_comb begin
            w_bf_d = r_mul;
            for (int b = 0; b < int'(HALF_N); b++) begin
                w_bf_d[bf_top(b, HALF)]        = mod_add(r_mul[bf_top(b, HALF)], r_mul[bf_top(b, HALF) + HALF]);
                w_bf_d[bf_top(b, HALF) + HALF] = mod_sub(r_mul[bf_top(b, HALF)], r_mul[bf_top(b, HALF) + HALF]);
            end
        end

        // NOTE: sequential state uses non-blocking assignments only. All
        // flops then sample the pre-edge values, whatever the block order.
        always_ff @(posedge clk or negedge r) begin
            if (!r) begin
                r_vld_mul  <= 1'b0;
                r_mode_mul <= 1'b0;
                r_vld_bf   <= 1'b0;
                r_mode_bf  <= 1'b0;
            end else if (w_adv) begin
                r_vld_mul  <= w_vld[s];
                r_mode_mul <= w_mode[s];
                r_vld_bf   <= r_vld_mul;
                r_mode_bf  <= r_mode_mul;
            end
        end

        // NOTE: the wide datapath registers have no reset. Their contents
        // matter only when the matching valid flag is set, and that flag is
        // reset.
        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_mul <= w_mul_d;
                r_bf  <= w_bf_d;
            end
        end

        assign w_data[s+1] = r_bf;
        assign w_vld[s+1]  = r_vld_bf;
        assign w_mode[s+1] = r_mode_bf;
    end

    // ---------------------------------------------------------------------
    // Final register: scale inverse vectors by N^-1; forward vectors pass.
    // ---------------------------------------------------------------------
    vec_t w_out_d;

    always_comb begin
        w_out_d = w_data[LOGN];
        if (w_mode[LOGN]) begin
            for (int i = 0; i < int'(N); i++) begin
                w_out_d[i] = mod_mul(w_data[LOGN][i], W'(N_INV));
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            valid_out  <= 1'b0;
            mode_out   <= 1'b0;
            coeffs_out <= '0;
        end else if (w_adv) begin
            valid_out  <= w_vld[LOGN];
            mode_out   <= w_mode[LOGN];
            coeffs_out <= w_out_d;
        end
    end

endmodule

// File: tb/tb_ntt_stream_core.sv
// -----------------------------------------------------------------------------
// tb_ntt_stream_core
//   Self-checking bench for ntt_stream_core (N=8, Q=3329). It combines
//   table-driven known vectors, hand-written reset, round-trip and stall
//   sequences, and randomized mixed-mode streams. The randomized streams are
//   compared against a direct O(N^2) transform model.
// -----------------------------------------------------------------------------
module tb_ntt_stream_core;

    localparam int N         = 8;
    localparam int W         = 12;
    localparam int Q         = 3329;
    localparam int OMEGA     = 2580;
    localparam int OMEGA_INV = 40;
    localparam int N_INV     = 2913;
    localparam int LAT       = 2 * $clog2(N) + 1;

    typedef logic [N-1:0][W-1:0] vec_t;

    typedef struct {
        logic mode;
        vec_t v;
    } txn_t;

    typedef struct {
        logic mode;
        vec_t din;
        vec_t dout;
    } vector_t;

    logic clk      = 1'b0;
    logic r_n      = 1'b1;
    logic valid_in = 1'b0;
    logic mode_in  = 1'b0;
    vec_t coeffs   = '0;
    logic valid_out;
    logic mode_out;
    vec_t coeffs_out;
    logic tb_acc;
    logic tb_take;

`ifdef NTT_BACKPRESSURE_EN
    logic in_ready;
    logic out_ready = 1'b1;
    assign tb_acc  = in_ready;
    assign tb_take = out_ready;
`else
    assign tb_acc  = 1'b1;
    assign tb_take = 1'b1;
`endif

    ntt_stream_core #(
        .N(N), .W(W), .Q(Q), .OMEGA(OMEGA), .OMEGA_INV(OMEGA_INV), .N_INV(N_INV)
    ) dut (
        .clk        (clk),
        .r          (r_n),
        .valid_in   (valid_in),
        .mode_in    (mode_in),
        .coeffs     (coeffs),
        .valid_out  (valid_out),
        .mode_out   (mode_out),
        .coeffs_out (coeffs_out)
`ifdef NTT_BACKPRESSURE_EN
        ,
        .in_ready   (in_ready),
        .out_ready  (out_ready)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    txn_t in_q[$];
    txn_t exp_q[$];
    txn_t obs_q[$];
    int   obs_cyc[$];

    // ---------------------------------------------------------------------
    // Checking helpers
    // ---------------------------------------------------------------------
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: direct definition of the cyclic transform
    // ---------------------------------------------------------------------
    function automatic longint pow_mod(input longint b, input int e);
        longint acc;
        acc = 1;
        for (int i = 0; i < e; i++) acc = (acc * b) % Q;
        return acc;
    endfunction

    function automatic vec_t ntt_model(input logic mode, input vec_t x);
        vec_t   y;
        longint acc;
        longint base;
        y    = '0;
        base = mode ? OMEGA_INV : OMEGA;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int j = 0; j < N; j++) begin
                acc = (acc + longint'(x[j]) * pow_mod(base, (j * k) % N)) % Q;
            end
            if (mode) acc = (acc * N_INV) % Q;
            y[k] = W'(acc);
        end
        return y;
    endfunction

    // ---------------------------------------------------------------------
    // Vector builders
    // ---------------------------------------------------------------------
    function automatic vec_t fill(input int v);
        vec_t x;
        for (int i = 0; i < N; i++) x[i] = W'(v);
        return x;
    endfunction

    function automatic vec_t unit(input int v);
        vec_t x;
        x    = '0;
        x[0] = W'(v);
        return x;
    endfunction

    function automatic vec_t ramp(input int step);
        vec_t x;
        for (int i = 0; i < N; i++) x[i] = W'((i + 1) * step);
        return x;
    endfunction

    function automatic vec_t rand_vec();
        vec_t x;
        for (int i = 0; i < N; i++) x[i] = W'($urandom_range(0, Q - 1));
        return x;
    endfunction

    // ---------------------------------------------------------------------
    // Cycle counter and output monitor (samples 1 ns after the falling edge)
    // ---------------------------------------------------------------------
    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (r_n && valid_out && tb_take) begin
            obs_q.push_back('{mode_out, coeffs_out});
            obs_cyc.push_back(cycle);
        end
    end

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    // Drives in_q back to back, holding each vector until it is accepted.
    task automatic drive_all();
        int guard;
        guard = 0;
        while (in_q.size() > 0 && guard < 500) begin
            @(negedge clk);
            valid_in = 1'b1;
            mode_in  = in_q[0].mode;
            coeffs   = in_q[0].v;
            #1;
            if (tb_acc) void'(in_q.pop_front());
            guard++;
        end
        @(negedge clk);
        valid_in = 1'b0;
        check("stream accepted", in_q.size(), 0);
        in_q.delete();
    endtask

    // Waits, within a bounded number of cycles, for all expected outputs.
    // It then compares the outputs in order and reports any extra or
    // missing vectors.
    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (obs_q.size() < exp_q.size() && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(negedge clk);
        check($sformatf("%s count", name), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check_vec($sformatf("%s data[%0d]", name, i), obs_q[i].v, exp_q[i].v);
            check($sformatf("%s mode[%0d]", name, i), obs_q[i].mode, exp_q[i].mode);
        end
    endtask

    // One isolated vector: no output before the 7th edge (counting the
    // transfer edge as edge 1), valid on that edge, gone one edge later.
    task automatic latency_vector(input vector_t tv, input int idx);
        int early;
        early = 0;
        @(negedge clk);
        valid_in = 1'b1;
        mode_in  = tv.mode;
        coeffs   = tv.din;
        for (int e = 1; e < LAT; e++) begin
            @(negedge clk);
            valid_in = 1'b0;
            if (valid_out) early++;
        end
        check($sformatf("tbl[%0d] early valid", idx), early, 0);
        @(negedge clk);
        check($sformatf("tbl[%0d] valid at latency", idx), valid_out, 1);
        check($sformatf("tbl[%0d] mode_out", idx), mode_out, tv.mode);
        check_vec($sformatf("tbl[%0d] coeffs_out", idx), coeffs_out, tv.dout);
        @(negedge clk);
        check($sformatf("tbl[%0d] one-cycle valid", idx), valid_out, 0);
        clear_obs();
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    vector_t tbl [9];

    initial begin
        vec_t f0;
        vec_t f1;
        int   rel_cycle;

        tbl[0] = '{1'b0, unit(1),    fill(1)};
        tbl[1] = '{1'b0, fill(1),    unit(8)};
        tbl[2] = '{1'b1, unit(8),    fill(1)};
        tbl[3] = '{1'b1, fill(1),    unit(1)};
        tbl[4] = '{1'b1, fill(3328), unit(3328)};
        tbl[5] = '{1'b0, fill(3328), unit(3321)};
        tbl[6] = '{1'b0, unit(3328), fill(3328)};
        tbl[7] = '{1'b0, fill(0),    fill(0)};
        tbl[8] = '{1'b1, unit(3328), fill(416)};

        // Power-on reset
        #2 r_n = 1'b0;
        #1;
        check("reset valid_out", valid_out, 0);
        check("reset mode_out", mode_out, 0);
        check_vec("reset coeffs_out", coeffs_out, '0);
        repeat (2) @(negedge clk);
        r_n = 1'b1;

        // Known vectors with exact latency
        for (int t = 0; t < 9; t++) latency_vector(tbl[t], t);

        // Reset mid-stream with several vectors in flight
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            mode_in  = i[0];
            coeffs   = rand_vec();
        end
        @(negedge clk);
        valid_in = 1'b0;
        check("pre-reset valid_out", valid_out, 1);
        r_n = 1'b0;
        #1;
        check("async reset valid_out", valid_out, 0);
        check("async reset mode_out", mode_out, 0);
        check_vec("async reset coeffs_out", coeffs_out, '0);
        repeat (2) @(negedge clk);
        clear_obs();
        r_n       = 1'b1;
        valid_in  = 1'b1;
        mode_in   = 1'b0;
        coeffs    = unit(1);
        rel_cycle = cycle;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (LAT + 8) @(negedge clk);
        check("post-reset output count", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            check_vec("post-reset first vector", obs_q[0].v, fill(1));
            check("post-reset latency", obs_cyc[0] - rel_cycle, LAT);
        end
        clear_obs();

        // Round trip: forward back to back, then inverse back to back
        in_q.push_back('{1'b0, ramp(1)});
        in_q.push_back('{1'b0, ramp(10)});
        exp_q.push_back('{1'b0, ntt_model(1'b0, ramp(1))});
        exp_q.push_back('{1'b0, ntt_model(1'b0, ramp(10))});
        drive_all();
        drain("fwd");
        f0 = (obs_q.size() > 0) ? obs_q[0].v : '0;
        f1 = (obs_q.size() > 1) ? obs_q[1].v : '0;
        clear_obs();
        exp_q.delete();
        in_q.push_back('{1'b1, f0});
        in_q.push_back('{1'b1, f1});
        exp_q.push_back('{1'b1, ramp(1)});
        exp_q.push_back('{1'b1, ramp(10)});
        drive_all();
        drain("roundtrip");
        clear_obs();
        exp_q.delete();

        // Mixed modes, 20 random vectors on consecutive cycles
        for (int i = 0; i < 20; i++) begin
            txn_t t;
            t.mode = i[0];
            t.v    = rand_vec();
            if (i == 3) t.v[N-1] = W'(Q - 1);
            in_q.push_back(t);
            exp_q.push_back('{t.mode, ntt_model(t.mode, t.v)});
        end
        drive_all();
        drain("mixed");
        if (obs_cyc.size() == 20) check("mixed consecutive valid", obs_cyc[19] - obs_cyc[0], 19);
        clear_obs();
        exp_q.delete();

`ifdef NTT_BACKPRESSURE_EN
        // Downstream stall for 5 cycles while streaming
        for (int i = 0; i < 12; i++) begin
            txn_t t;
            t.mode = ($urandom_range(0, 1) == 1);
            t.v    = rand_vec();
            in_q.push_back(t);
            exp_q.push_back('{t.mode, ntt_model(t.mode, t.v)});
        end
        fork
            drive_all();
            begin
                vec_t held;
                int   unstable;
                unstable = 0;
                repeat (LAT + 2) @(negedge clk);
                out_ready = 1'b0;
                #1;
                held = coeffs_out;
                check("stall valid_out", valid_out, 1);
                check("stall in_ready", in_ready, 0);
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    if (coeffs_out !== held || !valid_out || in_ready) unstable++;
                end
                check("stall stable", unstable, 0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("backpressure");
        clear_obs();
        exp_q.delete();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
